unidade_controle: RTL and testbench

Multicycle control FSM for the RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit `estado` bus and the `pcsrc` select consumed by the PC update stage, plus the register-file, memory and ALU enables. Opcode/funct3 come from the instruction register; `zero` comes from the ALU.

---
 rtl/unidade_controle.sv | 113 +++++++++++
 tb/tb_unidade_controle.sv | 123 ++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Multicycle control FSM for the RISC-V datapath: sequences fetch, decode,
// execute, memory and writeback, and produces the branch redirect select.
//
// state   | meaning
// FETCH   | read instruction (or PC redirect when pcsrc=1)
// DECODE  | latch opcode/funct3, flag unsupported encodings
// EXECUTE | ALU operation, branch condition evaluated on zero
// MEM     | data memory access (LOAD/STORE)
// WB      | register file writeback
module unidade_controle (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic [2:0] estado,
  output logic       pcsrc,
  output logic       ir_write,
  output logic       alu_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal
);

  typedef enum logic [2:0] {
    FETCH   = 3'b000,
    DECODE  = 3'b001,
    EXECUTE = 3'b010,
    MEM     = 3'b011,
    WB      = 3'b100
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  state_t     state_q;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       pcsrc_q;
  logic       bad_op;

  // Legality is judged on the live instruction bits while in DECODE.
  always_comb begin
    bad_op = 1'b0;
    if (state_q == DECODE) begin
      case (opcode)
        OP_R, OP_I, OP_LOAD, OP_STORE: bad_op = 1'b0;
        OP_BRANCH: bad_op = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
        default:   bad_op = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pcsrc_q <= 1'b0;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
    end else begin
      case (state_q)
        FETCH: begin
          // A pending redirect consumes one FETCH cycle, then the target is fetched.
          if (pcsrc_q) begin
            pcsrc_q <= 1'b0;
            state_q <= FETCH;
          end else begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          op_q <= opcode;
          f3_q <= funct3;
          state_q <= bad_op ? FETCH : EXECUTE;
        end
        EXECUTE: begin
          case (op_q)
            OP_R, OP_I:         state_q <= WB;
            OP_LOAD, OP_STORE:  state_q <= MEM;
            OP_BRANCH: begin
              pcsrc_q <= ((f3_q == F3_BEQ) && zero) || ((f3_q == F3_BNE) && !zero);
              state_q <= FETCH;
            end
            default:            state_q <= FETCH;
          endcase
        end
        MEM:     state_q <= (op_q == OP_LOAD) ? WB : FETCH;
        WB:      state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign estado     = state_q;
  assign pcsrc      = pcsrc_q;
  assign illegal    = bad_op;
  assign ir_write   = (state_q == FETCH) && !pcsrc_q;
  assign alu_src    = (state_q == EXECUTE) &&
                      ((op_q == OP_I) || (op_q == OP_LOAD) || (op_q == OP_STORE));
  assign mem_read   = (state_q == MEM) && (op_q == OP_LOAD);
  assign mem_write  = (state_q == MEM) && (op_q == OP_STORE);
  assign reg_write  = (state_q == WB);
  assign mem_to_reg = (state_q == WB) && (op_q == OP_LOAD);

endmodule

// File: tb/tb_unidade_controle.sv
// Directed vector bench for unidade_controle: per-cycle table of inputs and
// expected state/enables, plus hand-written asynchronous reset sequences.
module tb_unidade_controle;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] L  = 7'b0000011;
  localparam logic [6:0] S  = 7'b0100011;
  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] X  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic [2:0] estado;
  logic       pcsrc, ir_write, alu_src, mem_read, mem_write, reg_write, mem_to_reg, illegal;
  logic [7:0] flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic [2:0] est;
    logic [7:0] fl;  // {pcsrc, ir_write, alu_src, mem_read, mem_write, reg_write, mem_to_reg, illegal}
  } vec_t;

  vec_t v[64];
  int   nv = 0;

  unidade_controle dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .estado(estado), .pcsrc(pcsrc), .ir_write(ir_write), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign flags = {pcsrc, ir_write, alu_src, mem_read, mem_write, reg_write, mem_to_reg, illegal};

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic z,
                     input logic [2:0] est, input logic [7:0] fl);
    v[nv].op = op; v[nv].f3 = f3; v[nv].z = z; v[nv].est = est; v[nv].fl = fl;
    nv++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // R with opcode changing after DECODE: must still behave as R
    add(R, 0, 0, 0, 8'h40); add(R, 0, 0, 1, 8'h00); add(L, 0, 1, 2, 8'h00); add(S, 0, 0, 4, 8'h04);
    add(I, 0, 0, 0, 8'h40); add(I, 0, 0, 1, 8'h00); add(I, 0, 0, 2, 8'h20); add(I, 0, 0, 4, 8'h04);
    add(L, 0, 0, 0, 8'h40); add(L, 0, 0, 1, 8'h00); add(L, 0, 0, 2, 8'h20); add(L, 0, 0, 3, 8'h10);
    add(L, 0, 0, 4, 8'h06);
    add(S, 0, 0, 0, 8'h40); add(S, 0, 0, 1, 8'h00); add(S, 0, 0, 2, 8'h20); add(S, 0, 0, 3, 8'h08);
    // BEQ taken; live funct3 flips to BNE in EXECUTE, latched BEQ must win
    add(B, 0, 0, 0, 8'h40); add(B, 0, 0, 1, 8'h00); add(B, 1, 1, 2, 8'h00); add(B, 0, 0, 0, 8'h80);
    // refetch FETCH doubles as start of BEQ not taken
    add(B, 0, 0, 0, 8'h40); add(B, 0, 0, 1, 8'h00); add(B, 0, 0, 2, 8'h00);
    add(B, 1, 0, 0, 8'h40); add(B, 1, 0, 1, 8'h00); add(B, 1, 0, 2, 8'h00); add(B, 1, 0, 0, 8'h80);
    add(B, 1, 0, 0, 8'h40); add(B, 1, 0, 1, 8'h00); add(B, 1, 1, 2, 8'h00);
    add(B, 2, 0, 0, 8'h40); add(B, 2, 0, 1, 8'h01);
    add(X, 0, 0, 0, 8'h40); add(X, 0, 0, 1, 8'h01);
    add(R, 0, 0, 0, 8'h40);

    repeat (2) @(negedge clk);
    #1;
    chk("reset estado", {5'd0, estado}, 8'h00);
    chk("reset flags", flags, 8'h40);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      if (i > 0) @(negedge clk);
      opcode = v[i].op; funct3 = v[i].f3; zero = v[i].z;
      #1;
      chk($sformatf("vec%0d estado", i), {5'd0, estado}, {5'd0, v[i].est});
      chk($sformatf("vec%0d flags", i), flags, v[i].fl);
    end

    // Reset during MEM of a STORE: write enable must drop without a clock
    @(negedge clk); opcode = S; funct3 = 0; zero = 0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("store mem estado", {5'd0, estado}, 8'h03);
    chk("store mem flags", flags, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("rst in mem estado", {5'd0, estado}, 8'h00);
    chk("rst in mem flags", flags, 8'h40);
    @(negedge clk); rst_n = 1'b1;

    // Reset with pcsrc pending: redirect is dropped
    opcode = B; funct3 = 0; zero = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("pend estado", {5'd0, estado}, 8'h00);
    chk("pend flags", flags, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("rst pend estado", {5'd0, estado}, 8'h00);
    chk("rst pend flags", flags, 8'h40);
    @(negedge clk); rst_n = 1'b1; opcode = R; zero = 0;
    @(negedge clk); #1;
    chk("post rst estado", {5'd0, estado}, 8'h01);
    chk("post rst flags", flags, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
